// File: rtl/apb_requester.sv
// APB requester: turns a valid/ready command into APB SETUP/ACCESS transfers and returns one response per command.
// Optional feature: define APB_REQ_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states.
module apb_requester #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [DATA_W-1:0] CMD_WDATA,
  output logic              RSP_VALID,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              RSP_ERR,
  output logic              RSP_TIMEOUT,
  output logic              BUSY,
  output logic              PSELx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_cmd_ready;
  logic              r_busy;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_rsp_timeout;

  logic              w_aligned;
  logic              w_timeout;

  assign w_aligned = (CMD_ADDR[1:0] == 2'b00);

`ifdef APB_REQ_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_wait_cnt + CNT_W'(1);
  // Abort on the edge where this wait state would bring the count to the limit
  assign w_timeout = (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_IDLE && CMD_VALID && w_aligned) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_ACCESS && !PREADY) begin
      r_wait_cnt <= w_cnt_inc;
    end
  end
`else
  logic w_unused_timeout_cfg;

  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign w_timeout            = 1'b0;
`endif

  // Transfer FSM; all bus and response outputs are registered here
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state       <= S_IDLE;
      r_cmd_ready   <= 1'b1;
      r_busy        <= 1'b0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (CMD_VALID) begin
            if (w_aligned) begin
              r_state     <= S_SETUP;
              r_cmd_ready <= 1'b0;
              r_busy      <= 1'b1;
              r_psel      <= 1'b1;
              r_pwrite    <= CMD_WRITE;
              r_paddr     <= CMD_ADDR;
              r_pwdata    <= CMD_WDATA;
            end else begin
              r_rsp_valid   <= 1'b1;
              r_rsp_err     <= 1'b1;
              r_rsp_rdata   <= '0;
              r_rsp_timeout <= 1'b0;
            end
          end
        end
        S_SETUP: begin
          r_state   <= S_ACCESS;
          r_penable <= 1'b1;
        end
        S_ACCESS: begin
          if (PREADY || w_timeout) begin
            r_state       <= S_IDLE;
            r_cmd_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_err     <= PREADY ? PSLVERR : 1'b1;
            r_rsp_rdata   <= (PREADY && !r_pwrite) ? PRDATA : '0;
            r_rsp_timeout <= !PREADY;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_psel      <= 1'b0;
          r_penable   <= 1'b0;
        end
      endcase
    end
  end

  assign CMD_READY   = r_cmd_ready;
  assign BUSY        = r_busy;
  assign PSELx       = r_psel;
  assign PENABLE     = r_penable;
  assign PWRITE      = r_pwrite;
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;
  assign RSP_VALID   = r_rsp_valid;
  assign RSP_RDATA   = r_rsp_rdata;
  assign RSP_ERR     = r_rsp_err;
  assign RSP_TIMEOUT = r_rsp_timeout;

endmodule

// File: tb/tb_apb_requester.sv
// Self-checking bench for apb_requester: directed and random commands against a transaction-level model.
// Honours APB_REQ_TIMEOUT_EN when defined for both bench and design.
module tb_apb_requester;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TMO    = 4;
`ifdef APB_REQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              busy;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  int n_checks = 0;
  int n_fail   = 0;

  // Last response as predicted by the model, for hold checks in idle cycles
  logic [DATA_W-1:0] last_rdata = '0;
  logic              last_err   = 1'b0;
  logic              last_tmo   = 1'b0;

  always #5 clk = ~clk;

  apb_requester #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .PCLK(clk), .PRESET(rst),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WRITE(cmd_write),
    .CMD_ADDR(cmd_addr), .CMD_WDATA(cmd_wdata),
    .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err),
    .RSP_TIMEOUT(rsp_timeout), .BUSY(busy),
    .PSELx(psel), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr),
    .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_psel"}, psel, 0);
    check({tag, "_penable"}, penable, 0);
    check({tag, "_pwrite"}, pwrite, 0);
    check({tag, "_paddr"}, paddr, 0);
    check({tag, "_pwdata"}, pwdata, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_rsp_timeout"}, rsp_timeout, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
  endtask

  task automatic idle_cycle();
    pslverr = 1'($urandom);
    prdata  = $urandom;
    tick();
    check("idle_rsp_valid", rsp_valid, 0);
    check("idle_psel", psel, 0);
    check("idle_rsp_rdata_hold", rsp_rdata, last_rdata);
    check("idle_rsp_err_hold", rsp_err, last_err);
    check("idle_rsp_tmo_hold", rsp_timeout, last_tmo);
  endtask

  // Issue one command and play the completer; waits = PREADY-low ACCESS cycles before ready
  task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int waits, input logic [31:0] rd, input logic err);
    bit mis;
    bit tmo;
    int n_acc;
    logic [31:0] exp_rdata;
    logic exp_err;
    mis       = (addr[1:0] != 2'b00);
    tmo       = !mis && TMO_EN && (waits >= int'(TMO));
    n_acc     = tmo ? int'(TMO) : waits + 1;
    exp_rdata = (mis || tmo || wr) ? 32'h0 : rd;
    exp_err   = mis || tmo || err;

    check("cmd_ready_before", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    tick();
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    if (!mis) begin
      check("setup_psel", psel, 1);
      check("setup_penable", penable, 0);
      check("setup_paddr", paddr, addr);
      check("setup_pwrite", pwrite, wr);
      if (wr) check("setup_pwdata", pwdata, wdata);
      check("setup_cmd_ready", cmd_ready, 0);
      check("setup_busy", busy, 1);
      check("setup_rsp_valid", rsp_valid, 0);
      pready  = 1'($urandom);
      pslverr = 1'($urandom);
      prdata  = $urandom;
      tick();
      for (int k = 1; k <= n_acc; k++) begin
        check("access_psel", psel, 1);
        check("access_penable", penable, 1);
        check("access_paddr", paddr, addr);
        check("access_pwrite", pwrite, wr);
        check("access_cmd_ready", cmd_ready, 0);
        check("access_rsp_valid", rsp_valid, 0);
        if (k == n_acc && !tmo) begin
          pready  = 1'b1;
          prdata  = rd;
          pslverr = err;
        end else begin
          pready  = 1'b0;
          prdata  = $urandom;
          pslverr = 1'($urandom);
        end
        tick();
        pready  = 1'b0;
        prdata  = $urandom;
        pslverr = 1'($urandom);
      end
    end else begin
      check("mis_psel", psel, 0);
    end
    check("rsp_valid", rsp_valid, 1);
    check("rsp_err", rsp_err, exp_err);
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("rsp_timeout", rsp_timeout, tmo);
    check("rsp_psel", psel, 0);
    check("rsp_penable", penable, 0);
    check("rsp_busy", busy, 0);
    if (!mis) check("rsp_paddr_kept", paddr, addr);
    last_rdata = exp_rdata;
    last_err   = exp_err;
    last_tmo   = tmo;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();
    check_reset_outputs("post_reset");

    // Directed scenarios
    do_cmd(1'b1, 32'h8, 32'h0000_1A2B, 0, 32'h0, 1'b0);
    idle_cycle();
    do_cmd(1'b0, 32'h4, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
    idle_cycle();
    do_cmd(1'b0, 32'h4, 32'h0, 1, 32'h1234_5678, 1'b1);
    do_cmd(1'b1, 32'h0, 32'h0000_00A5, 0, 32'h0, 1'b0);
    idle_cycle();
    do_cmd(1'b1, 32'h6, 32'hFFFF_FFFF, 0, 32'h0, 1'b0);
    idle_cycle();
    do_cmd(1'b0, 32'h4, 32'h0, 100, 32'hCAFE_F00D, 1'b0);
    idle_cycle();
    do_cmd(1'b0, 32'hC, 32'h0, int'(TMO) - 1, 32'h0BAD_CAFE, 1'b0);
    idle_cycle();

    // Reset while in ACCESS: interrupted transfer yields no response
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0; cmd_wdata = 32'h55AA_55AA;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("rst_pre_penable", penable, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("rst_access");
    last_rdata = '0; last_err = 1'b0; last_tmo = 1'b0;
    for (int i = 0; i < 3; i++) idle_cycle();
    do_cmd(1'b1, 32'h8, 32'h0000_0F0F, 1, 32'h0, 1'b0);

    // Random commands
    for (int n = 0; n < 24; n++) begin
      logic [31:0] a;
      a = $urandom & 32'h0000_000C;
      if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
      do_cmd(1'($urandom), a, $urandom, int'($urandom_range(0, 6)), $urandom, 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
